// File: rtl/mem_io_arb_pkg.sv
// Shared types and the I/O window test for the I/D memory/I/O arbiter-decoder.
// Used by mem_io_arb_decode and io_onehot_dec.
package mem_io_arb_pkg;

  typedef enum logic [1:0] {IDLE, MEM, IO} state_t;
  typedef enum logic {OWN_I, OWN_D} owner_t;

  function automatic logic io_hit(input int unsigned addr,
                                  input int unsigned base,
                                  input int unsigned ports);
    return (addr >= base) && (addr <= base + ports - 1);
  endfunction

endpackage

// File: rtl/mem_io_arb_decode_io_onehot_dec.sv
// Combinational address -> one-hot I/O register select, with a window-hit flag.
// The top registers the select, so nothing here is timed.
module io_onehot_dec
  import mem_io_arb_pkg::*;
#(
  parameter int unsigned AW       = 8,
  parameter int unsigned IO_PORTS = 8,
  parameter int unsigned IO_BASE  = 2**AW - IO_PORTS
) (
  input  logic [AW-1:0]       addr,
  output logic [IO_PORTS-1:0] sel,
  output logic                valid
);

  always_comb begin
    valid = io_hit(32'(addr), IO_BASE, IO_PORTS);
    sel   = '0;
    for (int unsigned i = 0; i < IO_PORTS; i++)
      sel[i] = valid && (32'(addr) == IO_BASE + i);
  end

endmodule

// File: rtl/mem_io_arb_decode.sv
// I/D port arbiter for one shared memory port plus a one-hot I/O select with wait states.
// Define ADDR_ARB_RR_EN for round-robin on contention; otherwise D has fixed priority.
module mem_io_arb_decode
  import mem_io_arb_pkg::*;
#(
  parameter int unsigned AW       = 8,
  parameter int unsigned IO_PORTS = 8,
  parameter int unsigned IO_BASE  = 2**AW - IO_PORTS,
  parameter int unsigned IO_WAIT  = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_req,
  input  logic [AW-1:0]       i_addr,
  output logic                i_ack,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [AW-1:0]       d_addr,
  output logic                d_ack,
  output logic                mem_en,
  output logic                mem_we,
  output logic [AW-1:0]       mem_addr,
  output logic [IO_PORTS-1:0] io_sel,
  output logic                io_we
);

  localparam int unsigned CW = (IO_WAIT > 0) ? $clog2(IO_WAIT + 1) : 1;

  state_t              state, state_n;
  logic [CW-1:0]       cnt, cnt_n;
  owner_t              owner;
  logic                mem_en_n, mem_we_n, io_we_n, i_ack_n, d_ack_n;
  logic [AW-1:0]       mem_addr_n;
  logic [IO_PORTS-1:0] io_sel_n, dec_sel;
  logic                dec_valid;
`ifdef ADDR_ARB_RR_EN
  owner_t              last, last_n;
`endif

  io_onehot_dec #(.AW(AW), .IO_PORTS(IO_PORTS), .IO_BASE(IO_BASE)) u_dec (
    .addr  (d_addr),
    .sel   (dec_sel),
    .valid (dec_valid)
  );

  // NOTE: every signal gets a default before the case, so no path can infer a latch.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    mem_en_n   = 1'b0;
    mem_we_n   = 1'b0;
    mem_addr_n = '0;
    io_sel_n   = '0;
    io_we_n    = 1'b0;
    i_ack_n    = 1'b0;
    d_ack_n    = 1'b0;
`ifdef ADDR_ARB_RR_EN
    last_n     = last;
`endif
    unique case (state)
      IDLE: if (i_req || d_req) begin
`ifdef ADDR_ARB_RR_EN
        last_n = owner;
`endif
        if (owner == OWN_D && dec_valid) begin
          state_n  = IO;
          cnt_n    = '0;
          io_sel_n = dec_sel;
          io_we_n  = d_we;
          d_ack_n  = (IO_WAIT == 0);
        end else begin
          state_n    = MEM;
          mem_en_n   = 1'b1;
          mem_addr_n = (owner == OWN_D) ? d_addr : i_addr;
          mem_we_n   = (owner == OWN_D) && d_we;
          i_ack_n    = (owner == OWN_I);
          d_ack_n    = (owner == OWN_D);
        end
      end
      MEM: state_n = IDLE;
      IO: begin
        if (cnt == CW'(IO_WAIT)) begin
          state_n = IDLE;
        end else begin
          // Hold the captured select; the requester may already have moved on.
          cnt_n    = cnt + CW'(1);
          io_sel_n = io_sel;
          io_we_n  = io_we;
          d_ack_n  = (cnt_n == CW'(IO_WAIT));
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
`ifdef ADDR_ARB_RR_EN
    if (i_req && d_req) owner = (last == OWN_I) ? OWN_D : OWN_I;
    else                owner = d_req ? OWN_D : OWN_I;
`else
    owner = d_req ? OWN_D : OWN_I;
`endif
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      mem_en   <= 1'b0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      io_sel   <= '0;
      io_we    <= 1'b0;
      i_ack    <= 1'b0;
      d_ack    <= 1'b0;
`ifdef ADDR_ARB_RR_EN
      last     <= OWN_I;
`endif
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      mem_en   <= mem_en_n;
      mem_we   <= mem_we_n;
      mem_addr <= mem_addr_n;
      io_sel   <= io_sel_n;
      io_we    <= io_we_n;
      i_ack    <= i_ack_n;
      d_ack    <= d_ack_n;
`ifdef ADDR_ARB_RR_EN
      last     <= last_n;
`endif
    end
  end

endmodule

// File: tb/tb_mem_io_arb_decode.sv
// Self-checking bench: directed cases plus randomized I/D traffic against a
// transaction-level model that queues the expected output of every cycle.
module tb_mem_io_arb_decode;

  localparam int AW       = 8;
  localparam int IO_PORTS = 8;
  localparam int IO_BASE  = 248;
  localparam int IO_WAIT  = 1;

  logic clk = 1'b0, rst_n = 1'b0;
  logic i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [AW-1:0] i_addr = '0, d_addr = '0;
  logic i_ack, d_ack, mem_en, mem_we, io_we;
  logic [AW-1:0] mem_addr;
  logic [IO_PORTS-1:0] io_sel;

  logic i_req2 = 1'b0, d_req2 = 1'b0, d_we2 = 1'b0;
  logic [9:0] i_addr2 = '0, d_addr2 = '0;
  logic i_ack2, d_ack2, mem_en2, mem_we2, io_we2;
  logic [9:0] mem_addr2;
  logic [3:0] io_sel2;

  int vectors = 0, miscompares = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  mem_io_arb_decode dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_ack(d_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .io_sel(io_sel), .io_we(io_we)
  );

  mem_io_arb_decode #(.AW(10), .IO_PORTS(4), .IO_WAIT(0)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req2), .i_addr(i_addr2), .i_ack(i_ack2),
    .d_req(d_req2), .d_we(d_we2), .d_addr(d_addr2), .d_ack(d_ack2),
    .mem_en(mem_en2), .mem_we(mem_we2), .mem_addr(mem_addr2),
    .io_sel(io_sel2), .io_we(io_we2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    bit mem_en; bit mem_we; int mem_addr; int io_sel; bit io_we; bit i_ack; bit d_ack;
  } obs_t;

  obs_t exp_q[$];
  obs_t exp_cur = '{default: 0};
  bit   last_d  = 1'b0;

  // One granted access = its output cycles followed by the mandatory idle cycle.
  task automatic grant();
    bit   pick_d;
    obs_t o;
    int   off;
`ifdef ADDR_ARB_RR_EN
    pick_d = d_req && !(i_req && last_d);
`else
    pick_d = d_req;
`endif
    last_d = pick_d;
    off = int'(d_addr) - IO_BASE;
    if (pick_d && off >= 0 && off < IO_PORTS) begin
      for (int k = 0; k <= IO_WAIT; k++) begin
        o = '{default: 0};
        o.io_sel = 1 << off;
        o.io_we  = d_we;
        o.d_ack  = (k == IO_WAIT);
        exp_q.push_back(o);
      end
    end else begin
      o = '{default: 0};
      o.mem_en   = 1'b1;
      o.mem_addr = pick_d ? int'(d_addr) : int'(i_addr);
      o.mem_we   = pick_d && d_we;
      o.i_ack    = !pick_d;
      o.d_ack    = pick_d;
      exp_q.push_back(o);
    end
    o = '{default: 0};
    exp_q.push_back(o);
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      exp_cur = '{default: 0};
      last_d  = 1'b0;
    end else begin
      if (exp_q.size() == 0 && (i_req || d_req)) grant();
      if (exp_q.size() > 0) exp_cur = exp_q.pop_front();
      else                  exp_cur = '{default: 0};
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("mdl.mem_en", mem_en, exp_cur.mem_en);
      if (exp_cur.mem_en) begin
        check("mdl.mem_addr", mem_addr, exp_cur.mem_addr);
        check("mdl.mem_we", mem_we, exp_cur.mem_we);
      end
      check("mdl.io_sel", io_sel, exp_cur.io_sel);
      check("mdl.io_we", io_we, exp_cur.io_we);
      check("mdl.i_ack", i_ack, exp_cur.i_ack);
      check("mdl.d_ack", d_ack, exp_cur.d_ack);
    end
  end

  // ---------------- directed helpers ----------------
  task automatic expect_cycle(input string tag, input bit en, input int addr, input bit we,
                              input int sel, input bit iowe, input bit ia, input bit da);
    check({tag, ".mem_en"}, mem_en, en);
    if (en) begin
      check({tag, ".mem_addr"}, mem_addr, addr);
      check({tag, ".mem_we"}, mem_we, we);
    end
    check({tag, ".io_sel"}, io_sel, sel);
    check({tag, ".io_we"}, io_we, iowe);
    check({tag, ".i_ack"}, i_ack, ia);
    check({tag, ".d_ack"}, d_ack, da);
  endtask

  task automatic idle(input int n);
    i_req = 1'b0;
    d_req = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [AW-1:0] rand_addr();
    case ($urandom_range(3))
      0:       return 8'($urandom_range(255));
      1:       return 8'(IO_BASE + int'($urandom_range(IO_PORTS - 1)));
      2:       return 8'(IO_BASE - 1);
      default: return 8'(255);
    endcase
  endfunction

  initial begin
    bit exp_d;
    repeat (2) @(negedge clk);
    expect_cycle("reset", 0, 0, 0, 0, 0, 0, 0);
    #2 rst_n = 1'b1;
    cmp_en = 1'b1;

    // fetch to memory
    @(negedge clk); i_req = 1'b1; i_addr = 8'h12;
    @(negedge clk); expect_cycle("fetch", 1, 'h12, 0, 0, 0, 1, 0);
    idle(2);

    // I/O write with one wait state
    d_req = 1'b1; d_we = 1'b1; d_addr = 8'd250;
    @(negedge clk); expect_cycle("io_w1", 0, 0, 0, 'h04, 1, 0, 0);
    @(negedge clk); expect_cycle("io_w2", 0, 0, 0, 'h04, 1, 0, 1);
    d_req = 1'b0;
    @(negedge clk); expect_cycle("io_end", 0, 0, 0, 0, 0, 0, 0);
    idle(1);

    // window boundaries
    d_req = 1'b1; d_we = 1'b0; d_addr = 8'd247;
    @(negedge clk); expect_cycle("b247", 1, 247, 0, 0, 0, 0, 1);
    idle(2);
    d_req = 1'b1; d_addr = 8'd255;
    @(negedge clk); expect_cycle("b255a", 0, 0, 0, 'h80, 0, 0, 0);
    @(negedge clk); expect_cycle("b255b", 0, 0, 0, 'h80, 0, 0, 1);
    idle(2);
    i_req = 1'b1; i_addr = 8'd255;
    @(negedge clk); expect_cycle("i255", 1, 255, 0, 0, 0, 1, 0);
    idle(2);

    // contention with both requests held
    i_req = 1'b1; i_addr = 8'h20; d_req = 1'b1; d_we = 1'b0; d_addr = 8'h40;
    for (int k = 0; k < 3; k++) begin
`ifdef ADDR_ARB_RR_EN
      exp_d = (k % 2 == 0);
`else
      exp_d = 1'b1;
`endif
      @(negedge clk); expect_cycle("arb", 1, exp_d ? 'h40 : 'h20, 0, 0, 0, !exp_d, exp_d);
      @(negedge clk); expect_cycle("arb_gap", 0, 0, 0, 0, 0, 0, 0);
    end
    idle(2);

    // reset in the middle of an I/O access
    d_req = 1'b1; d_we = 1'b1; d_addr = 8'd252;
    @(negedge clk); expect_cycle("rst_pre", 0, 0, 0, 'h10, 1, 0, 0);
    #2 rst_n = 1'b0; d_req = 1'b0;
    #1 expect_cycle("rst_mid", 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); #2 rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk); check("rst_no_ack", {i_ack, d_ack}, 0);
    end

    // AW=10, IO_PORTS=4, IO_WAIT=0 instance
    d_req2 = 1'b1; d_addr2 = 10'd1021;
    @(negedge clk);
    check("p2.io_sel", io_sel2, 4'b0010);
    check("p2.d_ack", d_ack2, 1);
    check("p2.mem_en", mem_en2, 0);
    d_req2 = 1'b0;
    @(negedge clk);
    check("p2.d_ack_end", d_ack2, 0);
    check("p2.io_sel_end", io_sel2, 0);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (i_req && (i_ack || $urandom_range(99) < 2)) i_req = 1'b0;
      else if (!i_req && $urandom_range(99) < 40) begin
        i_req = 1'b1; i_addr = rand_addr();
      end
      if (d_req && (d_ack || $urandom_range(99) < 2)) d_req = 1'b0;
      else if (!d_req && $urandom_range(99) < 40) begin
        d_req = 1'b1; d_addr = rand_addr(); d_we = 1'($urandom_range(1));
      end
      if (c == 1500) begin
        #2 rst_n = 1'b0;
        @(negedge clk); #2 rst_n = 1'b1;
      end
    end
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
